rounding_unit: RTL and testbench
================================

ROUNDING_UNIT -- requirements
Module: rounding_unit

Interface
REQ-001 The block SHALL have parameter DataSize, default 24, meaning the mantissa width, leading bit included.
REQ-002 The block SHALL have parameter ExpSize, default 8, meaning the exponent width.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with ports as listed below.
REQ-004 Port clk: input, 1 bit, rising-edge clock.
REQ-005 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port InValid: input, 1 bit, upstream data valid.
REQ-007 Port InReady: output, 1 bit, block can accept data this cycle.
REQ-008 Port InData: input, DataSize bits, mantissa before rounding.
REQ-009 Port Guard, Round, Sticky: inputs, 1 bit each, guard, round and sticky bits below the mantissa LSB.
REQ-010 Port Sign: input, 1 bit, sign of the operand.
REQ-011 Port Exponent: input, ExpSize bits, biased exponent.
REQ-012 Port RoundMode: input, 2 bits; 00 = RNE, 01 = RTZ, 10 = RUP (toward +inf), 11 = RDN (toward -inf).
REQ-013 Port OutValid: output, 1 bit, result valid.
REQ-014 Port OutReady: input, 1 bit, downstream accepts the result.
REQ-015 Port RoundedData: output, DataSize bits, rounded and renormalised mantissa.
REQ-016 Port OutExponent: output, ExpSize bits, corrected exponent.
REQ-017 Port OutSign: output, 1 bit, Sign passed through.
REQ-018 Port Inexact: output, 1 bit, some discarded bit was nonzero.
REQ-019 Port Overflow: output, 1 bit, the exponent correction reached all-ones.

Function
REQ-020 A transfer SHALL occur on any rising edge where InValid and InReady are both 1, with RoundMode sampled together with the data.
REQ-021 The datapath SHALL be two registered stages: S1 computes the increment decision and Inexact; S2 performs the add and renormalisation.
REQ-022 Latency SHALL be 2 cycles: a transfer at edge N gives OutValid = 1 after edge N+1 when there is no backpressure.
REQ-023 Throughput SHALL be one result per cycle while OutReady = 1.
REQ-024 S2 SHALL load whenever S2 is empty or OutReady = 1.
REQ-025 S1 SHALL advance into S2 when S2 loads.
REQ-026 InReady SHALL equal (S1 empty) OR (S1 advancing), combinationally.
REQ-027 While OutValid = 1 and OutReady = 0, every output SHALL hold stable.
REQ-028 No data SHALL be lost or duplicated, and results SHALL leave in order.
REQ-029 Inexact SHALL equal Guard OR Round OR Sticky.
REQ-030 The increment decision inc SHALL be:
- RNE: Guard AND (InData[0] OR Round OR Sticky)
- RTZ: 0
- RUP: NOT Sign AND Inexact
- RDN: Sign AND Inexact
REQ-031 The sum SHALL be the (DataSize+1)-bit value InData + inc.
REQ-032 When the sum carries out, RoundedData SHALL be sum[DataSize:1] (leading 1 followed by zeros) and OutExponent SHALL be Exponent + 1.
REQ-033 When the sum does not carry out, RoundedData SHALL be sum[DataSize-1:0] and OutExponent SHALL be Exponent.
REQ-034 Overflow SHALL be 1 exactly when a carry occurs and Exponent + 1 equals all-ones.
REQ-035 When Exponent is all-ones (Inf/NaN) on input, the block SHALL force inc = 0, Inexact = 0 and Overflow = 0, and pass InData and Exponent through unchanged.
REQ-036 The exponent increment SHALL NOT wrap, because the all-ones input case is excluded by REQ-035.
REQ-037 A simultaneous input transfer and output drain SHALL keep the pipeline full at one result per cycle.

Reset
REQ-038 While rst_n = 0, S1/S2 valid flags, OutValid, RoundedData, OutExponent, OutSign, Inexact and Overflow SHALL all be 0, asynchronously.
REQ-039 InReady SHALL be 1 during reset and in the first cycle after reset.
REQ-040 Asserting reset mid-operation SHALL discard in-flight data; OutValid SHALL drop to 0 without waiting for a clock edge.
REQ-041 After reset is released, the first valid result SHALL come only from data transferred after release.

Verification (DataSize = 8, ExpSize = 8)
REQ-042 Bench SHALL cover RNE ties:
- InData 0x04, G=1 R=0 S=0 -> 0x04, Inexact 1
- InData 0x05, same G/R/S -> 0x06
REQ-043 Bench SHALL cover carry: InData 0xFF, G=1 S=1, Exponent 0x10, RNE -> RoundedData 0x80, OutExponent 0x11, Overflow 0.
REQ-044 Bench SHALL cover overflow and special:
- InData 0xFF, G=1, Exponent 0xFE -> OutExponent 0xFF, RoundedData 0x80, Overflow 1
- Exponent 0xFF input -> data unchanged, flags 0
REQ-045 Bench SHALL cover modes with InData 0x10, G=1:
- RTZ -> 0x10
- RUP, Sign 0 -> 0x11
- RUP, Sign 1 -> 0x10
- RDN, Sign 1 -> 0x11
REQ-046 Bench SHALL cover backpressure: OutReady held 0 while 4 inputs are offered -> exactly 2 accepted, InReady 0 afterwards, outputs stable; on OutReady release, all results arrive in order.
REQ-047 Bench SHALL cover reset: rst_n pulsed low with both stages full -> OutValid 0 immediately, all outputs 0, InReady 1.

Source files
------------

// File: rtl/rounding_unit.sv
// Two-stage IEEE-style mantissa rounding: S1 decides the increment and the
// inexact flag, S2 adds and renormalises. Valid/ready handshake on both sides.
module rounding_unit #(
   parameter int unsigned DataSize = 24,
   parameter int unsigned ExpSize  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                InValid,
   output logic                InReady,
   input  logic [DataSize-1:0] InData,
   input  logic                Guard,
   input  logic                Round,
   input  logic                Sticky,
   input  logic                Sign,
   input  logic [ExpSize-1:0]  Exponent,
   input  logic [1:0]          RoundMode,
   output logic                OutValid,
   input  logic                OutReady,
   output logic [DataSize-1:0] RoundedData,
   output logic [ExpSize-1:0]  OutExponent,
   output logic                OutSign,
   output logic                Inexact,
   output logic                Overflow
);

   typedef enum logic [1:0] {
      RNE = 2'b00,
      RTZ = 2'b01,
      RUP = 2'b10,
      RDN = 2'b11
   } round_mode_t;

   // S1 registers
   logic                s1_valid;
   logic [DataSize-1:0] s1_data;
   logic [ExpSize-1:0]  s1_exp;
   logic                s1_sign;
   logic                s1_inc;
   logic                s1_inexact;

   logic s2_load;
   logic in_fire;

   assign s2_load  = ~OutValid | OutReady;
   assign InReady  = ~s1_valid | s2_load;
   assign in_fire  = InValid & InReady;

   // S1 decision logic
   logic special;
   logic any_lost;
   logic inc_raw;

   always_comb begin
      special  = &Exponent;
      any_lost = Guard | Round | Sticky;
      inc_raw  = 1'b0;
      case (round_mode_t'(RoundMode))
         RNE:     inc_raw = Guard & (InData[0] | Round | Sticky);
         RTZ:     inc_raw = 1'b0;
         RUP:     inc_raw = ~Sign & any_lost;
         RDN:     inc_raw = Sign & any_lost;
         default: inc_raw = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_data    <= '0;
         s1_exp     <= '0;
         s1_sign    <= 1'b0;
         s1_inc     <= 1'b0;
         s1_inexact <= 1'b0;
      end else if (in_fire) begin
         s1_valid   <= 1'b1;
         s1_data    <= InData;
         s1_exp     <= Exponent;
         s1_sign    <= Sign;
         s1_inc     <= inc_raw & ~special;
         s1_inexact <= any_lost & ~special;
      end else if (s2_load) begin
         s1_valid   <= 1'b0;
      end
   end

   // S2 add and renormalise; Inf/NaN inputs never increment, so no carry
   logic [DataSize:0]   sum;
   logic                carry;
   logic [ExpSize-1:0]  exp_inc;
   logic [DataSize-1:0] norm_data;
   logic [ExpSize-1:0]  norm_exp;
   logic                ovf;

   always_comb begin
      sum       = {1'b0, s1_data} + (DataSize+1)'(s1_inc);
      carry     = sum[DataSize];
      exp_inc   = s1_exp + ExpSize'(1);
      norm_data = carry ? sum[DataSize:1] : sum[DataSize-1:0];
      norm_exp  = carry ? exp_inc : s1_exp;
      ovf       = carry & (&exp_inc);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         OutValid    <= 1'b0;
         RoundedData <= '0;
         OutExponent <= '0;
         OutSign     <= 1'b0;
         Inexact     <= 1'b0;
         Overflow    <= 1'b0;
      end else if (s2_load) begin
         OutValid <= s1_valid;
         if (s1_valid) begin
            RoundedData <= norm_data;
            OutExponent <= norm_exp;
            OutSign     <= s1_sign;
            Inexact     <= s1_inexact;
            Overflow    <= ovf;
         end
      end
   end

endmodule

// File: tb/tb_rounding_unit.sv
// Directed-vector bench for rounding_unit (DataSize = 8, ExpSize = 8).
module tb_rounding_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       InValid;
   logic       InReady;
   logic [7:0] InData;
   logic       Guard, Round, Sticky, Sign;
   logic [7:0] Exponent;
   logic [1:0] RoundMode;
   logic       OutValid;
   logic       OutReady;
   logic [7:0] RoundedData;
   logic [7:0] OutExponent;
   logic       OutSign, Inexact, Overflow;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   always #5 clk = ~clk;

   rounding_unit #(.DataSize(8), .ExpSize(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .InValid(InValid), .InReady(InReady), .InData(InData),
      .Guard(Guard), .Round(Round), .Sticky(Sticky), .Sign(Sign),
      .Exponent(Exponent), .RoundMode(RoundMode),
      .OutValid(OutValid), .OutReady(OutReady),
      .RoundedData(RoundedData), .OutExponent(OutExponent),
      .OutSign(OutSign), .Inexact(Inexact), .Overflow(Overflow)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic [7:0] d, input logic g, input logic r, input logic s,
                        input logic sg, input logic [7:0] e, input logic [1:0] m);
      InValid = 1'b1; InData = d; Guard = g; Round = r; Sticky = s;
      Sign = sg; Exponent = e; RoundMode = m;
   endtask

   // single transfer with OutReady high; result checked one edge after transfer
   task automatic run_vec(input string tag, input logic [7:0] d, input logic g, input logic r,
                          input logic s, input logic sg, input logic [7:0] e, input logic [1:0] m,
                          input logic [7:0] xd, input logic [7:0] xe, input logic xi, input logic xo);
      drive(d, g, r, s, sg, e, m);
      @(posedge clk); #1;
      InValid = 1'b0;
      @(posedge clk); #1;
      check({tag, ".valid"}, 32'(OutValid), 32'd1);
      check({tag, ".data"},  32'(RoundedData), 32'(xd));
      check({tag, ".exp"},   32'(OutExponent), 32'(xe));
      check({tag, ".sign"},  32'(OutSign), 32'(sg));
      check({tag, ".inex"},  32'(Inexact), 32'(xi));
      check({tag, ".ovf"},   32'(Overflow), 32'(xo));
   endtask

   int unsigned accepted;
   int unsigned k;
   int unsigned got;
   logic [7:0]  res [0:7];
   logic [7:0]  hold_d;

   initial begin
      rst_n = 1'b0; OutReady = 1'b1;
      drive(8'h00, 0, 0, 0, 0, 8'h00, 2'b00); InValid = 1'b0;
      #12;
      check("rst.outvalid", 32'(OutValid), 32'd0);
      check("rst.inready",  32'(InReady), 32'd1);
      check("rst.data",     32'(RoundedData), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst.inready", 32'(InReady), 32'd1);

      run_vec("rne_tie_even", 8'h04, 1, 0, 0, 0, 8'h10, 2'b00, 8'h04, 8'h10, 1, 0);
      run_vec("rne_tie_odd",  8'h05, 1, 0, 0, 0, 8'h10, 2'b00, 8'h06, 8'h10, 1, 0);
      run_vec("rne_above",    8'h10, 1, 1, 0, 0, 8'h10, 2'b00, 8'h11, 8'h10, 1, 0);
      run_vec("carry",        8'hFF, 1, 0, 1, 0, 8'h10, 2'b00, 8'h80, 8'h11, 1, 0);
      run_vec("overflow",     8'hFF, 1, 0, 0, 0, 8'hFE, 2'b00, 8'h80, 8'hFF, 1, 1);
      run_vec("special",      8'hFF, 1, 1, 1, 0, 8'hFF, 2'b10, 8'hFF, 8'hFF, 0, 0);
      run_vec("rtz",          8'h10, 1, 0, 0, 0, 8'h10, 2'b01, 8'h10, 8'h10, 1, 0);
      run_vec("rup_pos",      8'h10, 1, 0, 0, 0, 8'h10, 2'b10, 8'h11, 8'h10, 1, 0);
      run_vec("rup_neg",      8'h10, 1, 0, 0, 1, 8'h10, 2'b10, 8'h10, 8'h10, 1, 0);
      run_vec("rdn_neg",      8'h10, 1, 0, 0, 1, 8'h10, 2'b11, 8'h11, 8'h10, 1, 0);
      run_vec("exact",        8'h3C, 0, 0, 0, 0, 8'h20, 2'b10, 8'h3C, 8'h20, 0, 0);
      @(posedge clk); #1;

      // backpressure: offer 0x20..0x23 with OutReady low
      OutReady = 1'b0; accepted = 0; k = 0;
      for (int c = 0; c < 4; c++) begin
         drive(8'h20 + 8'(k), 0, 0, 0, 0, 8'h30, 2'b01);
         @(negedge clk);
         if (InReady) begin accepted++; k++; end
         @(posedge clk); #1;
      end
      InValid = 1'b0;
      check("bp.accepted", 32'(accepted), 32'd2);
      check("bp.inready",  32'(InReady), 32'd0);
      check("bp.outvalid", 32'(OutValid), 32'd1);
      hold_d = RoundedData;
      check("bp.head", 32'(hold_d), 32'h20);
      repeat (3) @(posedge clk);
      #1;
      check("bp.stable", 32'(RoundedData), 32'(hold_d));
      check("bp.stable_v", 32'(OutValid), 32'd1);
      OutReady = 1'b1; got = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (OutValid && got < 8) begin res[got] = RoundedData; got++; end
      end
      check("bp.count", 32'(got), 32'd2);
      check("bp.order0", 32'(res[0]), 32'h20);
      check("bp.order1", 32'(res[1]), 32'h21);

      // streaming: back-to-back inputs, one result per cycle
      @(posedge clk); #1;
      got = 0; k = 0;
      for (int c = 0; c < 10; c++) begin
         if (k < 4) drive(8'h40 + 8'(k), 0, 0, 0, 0, 8'h30, 2'b01);
         else InValid = 1'b0;
         @(negedge clk);
         if (InValid && InReady) k++;
         if (OutValid && got < 8) begin res[got] = RoundedData; got++; end
         @(posedge clk); #1;
      end
      InValid = 1'b0;
      check("stream.accepted", 32'(k), 32'd4);
      check("stream.count", 32'(got), 32'd4);
      check("stream.first", 32'(res[0]), 32'h40);
      check("stream.last",  32'(res[3]), 32'h43);

      // reset with both stages full
      OutReady = 1'b0;
      for (int c = 0; c < 2; c++) begin
         drive(8'hFF, 1, 0, 0, 1, 8'h10, 2'b11);
         @(posedge clk); #1;
      end
      InValid = 1'b0;
      check("rst2.pre_valid", 32'(OutValid), 32'd1);
      check("rst2.pre_inready", 32'(InReady), 32'd0);
      @(negedge clk); #2;
      rst_n = 1'b0; #1;
      check("rst2.outvalid", 32'(OutValid), 32'd0);
      check("rst2.outs", {8'(RoundedData), 8'(OutExponent), 5'(0), OutSign, Inexact, Overflow}, 32'd0);
      check("rst2.inready", 32'(InReady), 32'd1);
      @(negedge clk); rst_n = 1'b1; OutReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst2.no_stale", 32'(OutValid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
